// File: rtl/acc_spi_reader.sv
// acc_spi_reader: SPI mode-3 master that periodically burst-reads six bytes
// (X/Y/Z low/high) from a 3-axis accelerometer. It presents the three axes as
// one signed sample set on a valid/ready handshake, with an overrun pulse when
// an unaccepted set is replaced.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   enable                 1 = issue periodic reads; 0 = finish frame, then idle
//   spi_sclk/cs_n/mosi     registered SPI master outputs (sclk idles high)
//   spi_miso               SPI master input
//   acc_x/acc_y/acc_z      signed samples {H,L}
//   acc_valid/acc_ready    output handshake
//   overrun                1-cycle pulse when an unaccepted set is overwritten
module acc_spi_reader #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter logic [5:0]  START_ADDR    = 6'h28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] acc_x,
    output logic [15:0] acc_y,
    output logic [15:0] acc_z,
    output logic        acc_valid,
    input  logic        acc_ready,
    output logic        overrun
);

    localparam int unsigned CNT_W  = $clog2(SAMPLE_PERIOD);
    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned BIT_W  = 6;
    localparam int unsigned N_BITS = 56;
    localparam int unsigned SR_W   = 48;
    localparam logic [7:0]  CMD    = {1'b1, 1'b1, START_ADDR};

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic               mosi_q, mosi_d;
    logic [15:0]        x_q, x_d, y_q, y_d, z_q, z_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               tick_c;
    logic               div_last_c;
    logic               load_c;
    logic [BIT_W-1:0]   nb_c;

    // Free-running sample period counter
    always_comb begin
        tick_c = (cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
        cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    // Frame sequencer and SPI pin generation
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        load_c     = 1'b0;
        div_last_c = (div_q == DIV_W'(CLK_DIV - 1));
        nb_c       = bit_q + BIT_W'(1);

        case (state_q)
            IDLE: begin
                if (tick_c && enable) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    mosi_d  = CMD[7];
                    div_d   = '0;
                end
            end
            SETUP: begin
                if (div_last_c) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (!div_last_c) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK: capture MISO; command-phase bits fall off the top
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[SR_W-2:0], spi_miso};
                    end else if (bit_q == BIT_W'(N_BITS - 1)) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        // Falling SCLK: advance to next bit, MOSI changes here only
                        sclk_d = 1'b0;
                        bit_d  = nb_c;
                        mosi_d = (nb_c < BIT_W'(8)) ? CMD[~nb_c[2:0]] : 1'b0;
                    end
                end
            end
            HOLD: begin
                if (div_last_c) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    load_c  = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample set output and handshake; shift register holds XL,XH,YL,YH,ZL,ZH
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (load_c) begin
            x_d     = {sr_q[39:32], sr_q[47:40]};
            y_d     = {sr_q[23:16], sr_q[31:24]};
            z_d     = {sr_q[7:0],   sr_q[15:8]};
            valid_d = 1'b1;
            ovr_d   = valid_q && !acc_ready;
        end else if (valid_q && acc_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;
    assign acc_x     = x_q;
    assign acc_y     = y_q;
    assign acc_z     = z_q;
    assign acc_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_acc_spi_reader.sv
// Bench for acc_spi_reader: accelerometer SPI slave model, frame-level
// reference of the output handshake, directed phases with random data/ready.
module tb_acc_spi_reader;

    localparam int CD  = 4;
    localparam int SP  = 1000;
    localparam int LAT = 1 + CD * 114;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso = 1'b0;
    logic [15:0] acc_x, acc_y, acc_z;
    logic        acc_valid, overrun;
    logic        acc_ready = 1'b0;

    acc_spi_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .START_ADDR(6'h28)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- sensor model ----------------
    logic [7:0] sb [6];
    logic [7:0] cmd_seen;
    int frame_no = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    logic        pend = 1'b0;
    logic [15:0] pend_x, pend_y, pend_z;

    always @(negedge spi_cs_n) begin
        if (frame_no == 0) begin
            sb[0] = 8'h34; sb[1] = 8'h12; sb[2] = 8'hCD;
            sb[3] = 8'hAB; sb[4] = 8'h00; sb[5] = 8'h80;
        end else begin
            for (int i = 0; i < 6; i++) sb[i] = 8'($urandom);
        end
        frame_no++;
        rise_cnt = 0;
        fall_cnt = 0;
        cmd_seen = 8'h00;
    end

    // Data bit k of the burst is bit (7 - k%8) of byte k/8, driven on SCLK fall
    always @(negedge spi_sclk) begin
        if (!spi_cs_n && rst_n) begin
            if (fall_cnt >= 8 && fall_cnt < 56)
                spi_miso = sb[(fall_cnt - 8) / 8][7 - ((fall_cnt - 8) % 8)];
            fall_cnt++;
        end
    end

    always @(posedge spi_sclk) begin
        if (!spi_cs_n && rst_n) begin
            if (rise_cnt < 8) cmd_seen = {cmd_seen[6:0], spi_mosi};
            rise_cnt++;
        end
    end

    always @(posedge spi_cs_n) begin
        if (rst_n) begin
            check_eq("cmd_byte", 32'(cmd_seen), 32'h E8);
            check_eq("sclk_rises", 32'(rise_cnt), 32'd56);
            pend   = 1'b1;
            pend_x = {sb[1], sb[0]};
            pend_y = {sb[3], sb[2]};
            pend_z = {sb[5], sb[4]};
        end
    end

    // ---------------- handshake reference ----------------
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int mode = 1;          // 0: ready low, 1: ready high, 2: random, 3: high only at load
    logic        mvalid = 1'b0;
    logic [15:0] ex = '0, ey = '0, ez = '0;
    logic        cs_prev = 1'b1;
    int fall_cyc = 0;
    int n_starts = 0;
    int n_loads = 0;
    int n_ov = 0;
    int bad_idle = 0;

    always @(negedge clk) begin
        logic load, eov;
        if (!rst_n) begin
            mvalid  = 1'b0;
            pend    = 1'b0;
            cs_prev = 1'b1;
            ex = '0; ey = '0; ez = '0;
        end else begin
            if (cs_prev && !spi_cs_n) begin
                n_starts++;
                fall_cyc = cyc;
                check_eq("start_phase", 32'(cyc % SP), 32'd0);
            end
            if (!cs_prev && spi_cs_n)
                check_eq("frame_latency", 32'(cyc - fall_cyc), 32'(LAT - 1));
            cs_prev = spi_cs_n;
            if (spi_cs_n && !spi_sclk) bad_idle++;

            load = pend;
            pend = 1'b0;
            eov  = load && mvalid && !acc_ready;
            if (load) begin
                mvalid = 1'b1;
                ex = pend_x; ey = pend_y; ez = pend_z;
                n_loads++;
            end else if (mvalid && acc_ready) begin
                mvalid = 1'b0;
            end
            check_eq("acc_valid", 32'(acc_valid), 32'(mvalid));
            check_eq("overrun", 32'(overrun), 32'(eov));
            if (overrun) n_ov++;
            if (mvalid) begin
                check_eq("acc_x", 32'(acc_x), 32'(ex));
                check_eq("acc_y", 32'(acc_y), 32'(ey));
                check_eq("acc_z", 32'(acc_z), 32'(ez));
            end

            case (mode)
                0:       acc_ready = 1'b0;
                1:       acc_ready = 1'b1;
                2:       acc_ready = 1'($urandom_range(0, 1));
                default: acc_ready = !spi_cs_n && (cyc == fall_cyc + LAT - 2);
            endcase
        end
    end

    task automatic wait_loads(input int n);
        int target;
        target = n_loads + n;
        for (int i = 0; i < (n + 1) * SP + 100; i++) begin
            @(negedge clk); #1;
            if (n_loads >= target) break;
        end
        check_eq("wait_loads", 32'(n_loads >= target), 32'd1);
    endtask

    task automatic wait_bit(input int b);
        for (int i = 0; i < 2 * SP; i++) begin
            @(posedge clk); #2;
            if (!spi_cs_n && rise_cnt == b) break;
        end
        check_eq("wait_bit", 32'(!spi_cs_n && rise_cnt == b), 32'd1);
    endtask

    initial begin
        int ov0, s0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check_eq("rst_sclk", 32'(spi_sclk), 32'd1);
        check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
        check_eq("rst_acc", {acc_x, acc_y | acc_z}, 32'd0);
        check_eq("rst_valid", 32'(acc_valid), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        mode   = 1;

        // Fixed first frame
        wait_loads(1);
        check_eq("first_x", 32'(acc_x), 32'h1234);
        check_eq("first_y", 32'(acc_y), 32'hABCD);
        check_eq("first_z", 32'(acc_z), 32'h8000);

        // Random data, random ready
        mode = 2;
        wait_loads(3);

        // Drain, then two unaccepted frames: exactly one overrun
        mode = 1;
        repeat (4) @(negedge clk);
        #1;
        mode = 0;
        ov0 = n_ov;
        wait_loads(2);
        check_eq("ovr_two_frames", 32'(n_ov - ov0), 32'd1);
        check_eq("valid_held", 32'(acc_valid), 32'd1);

        // Acceptance coincides with load: no overrun
        mode = 3;
        ov0 = n_ov;
        wait_loads(1);
        check_eq("ovr_accept_at_load", 32'(n_ov - ov0), 32'd0);
        mode = 0;

        // Reset in the middle of SHIFT
        wait_bit(20);
        check_eq("pre_reset_valid", 32'(acc_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check_eq("abort_sclk", 32'(spi_sclk), 32'd1);
        check_eq("abort_valid", 32'(acc_valid), 32'd0);
        check_eq("abort_acc_x", 32'(acc_x), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        mode  = 2;
        wait_loads(1);

        // enable dropped mid-frame: frame still delivers, then no frames
        mode = 0;
        wait_bit(10);
        enable = 1'b0;
        wait_loads(1);
        check_eq("valid_after_disable", 32'(acc_valid), 32'd1);
        s0 = n_starts;
        repeat (3 * SP) @(negedge clk);
        check_eq("no_start_disabled", 32'(n_starts), 32'(s0));
        #1;
        enable = 1'b1;
        mode   = 1;
        for (int i = 0; i < SP + 10; i++) begin
            @(negedge clk); #1;
            if (n_starts > s0) break;
        end
        check_eq("restart_after_enable", 32'(n_starts > s0), 32'd1);
        wait_loads(1);

        check_eq("sclk_high_when_idle", 32'(bad_idle), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
